// File: rtl/regfile_dump_pkg.sv
// Shared widths for the register-file dump engine.
// The data width tracks the project-wide DATA_WIDTH define when the build provides one.
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

package regfile_dump_pkg;

  localparam int DATA_WIDTH = `DATA_WIDTH;
  localparam int REG_IDX_W  = 5;

  typedef logic [REG_IDX_W-1:0]  reg_idx_t;
  typedef logic [DATA_WIDTH-1:0] reg_data_t;

endpackage

// File: rtl/regfile_dump.sv
// Walks register indices START_REG..END_REG over the rs1/rd1 read port and
// presents each index/value pair on a valid/ready stream, then pulses done.
module regfile_dump
  import regfile_dump_pkg::*;
#(
  parameter int unsigned START_REG = 1,
  parameter int unsigned END_REG   = 31
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic [REG_IDX_W-1:0]  rs_addr,
  input  logic [DATA_WIDTH-1:0] rd_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [REG_IDX_W-1:0]  out_addr,
  output logic [DATA_WIDTH-1:0] out_data
);

  // Encodings stay private to this block; nothing outside observes the state.
  typedef enum logic [1:0] {
    IDLE,
    READ,
    HOLD,
    DONE
  } state_t;

  localparam reg_idx_t START_IDX = START_REG[REG_IDX_W-1:0];
  localparam reg_idx_t END_IDX   = END_REG[REG_IDX_W-1:0];

  state_t state;

  // NOTE: every register here uses non-blocking assignment so all outputs
  // update together on the edge and READ samples the pre-edge rd_data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      rs_addr   <= '0;
      out_valid <= 1'b0;
      out_addr  <= '0;
      out_data  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            rs_addr <= START_IDX;
            busy    <= 1'b1;
            state   <= READ;
          end
        end

        READ: begin
          out_data  <= rd_data;
          out_addr  <= rs_addr;
          out_valid <= 1'b1;
          state     <= HOLD;
        end

        HOLD: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            // END_REG <= 31 ends the pass before the 5-bit increment can wrap.
            if (out_addr == END_IDX) begin
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= DONE;
            end else begin
              rs_addr <= out_addr + 1'b1;
              state   <= READ;
            end
          end
        end

        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
